// File: rtl/drive_cmd_scheduler_pkg.sv
// Shared types and helpers for the drive command scheduler.
package drive_cmd_scheduler_pkg;

  typedef enum logic [2:0] {
    CMD_STOP       = 3'd0,
    CMD_TURN_LEFT  = 3'd1,
    CMD_LEFT       = 3'd2,
    CMD_STRAIGHT   = 3'd3,
    CMD_RIGHT      = 3'd4,
    CMD_TURN_RIGHT = 3'd5
  } drive_cmd_t;

  typedef enum logic [1:0] {
    SRC_AUTO   = 2'd0,
    SRC_MANUAL = 2'd1,
    SRC_ESTOP  = 2'd2
  } src_t;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BRAKE = 2'd2
  } sched_state_t;

  // Raw 3-bit code to command; undefined codes 6/7 collapse to Stop.
  function automatic drive_cmd_t norm_cmd(input logic [2:0] c);
    return (c > 3'd5) ? CMD_STOP : drive_cmd_t'(c);
  endfunction

  function automatic logic is_left_fam(input drive_cmd_t c);
    return (c == CMD_TURN_LEFT) || (c == CMD_LEFT);
  endfunction

  function automatic logic is_right_fam(input drive_cmd_t c);
    return (c == CMD_RIGHT) || (c == CMD_TURN_RIGHT);
  endfunction

  // True when moving from a to b flips the turning direction.
  function automatic logic is_reversal(input drive_cmd_t a, input drive_cmd_t b);
    return (is_left_fam(a) && is_right_fam(b)) || (is_right_fam(a) && is_left_fam(b));
  endfunction

endpackage

// File: rtl/drive_cmd_scheduler_if.sv
// Command-source inputs, downstream valid/ready link and status outputs.
interface drive_cmd_scheduler_if;

  logic [2:0] auto_cmd;
  logic       auto_valid;
  logic [2:0] manual_cmd;
  logic       manual_valid;
  logic       estop;
  logic [2:0] out_cmd;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] active_src;
  logic       busy;

  modport master (
    output auto_cmd, auto_valid, manual_cmd, manual_valid, estop, out_ready,
    input  out_cmd, out_valid, active_src, busy
  );

  modport slave (
    input  auto_cmd, auto_valid, manual_cmd, manual_valid, estop, out_ready,
    output out_cmd, out_valid, active_src, busy
  );

endinterface

// File: rtl/drive_cmd_scheduler_sched_timer.sv
// Saturating up-counter with synchronous load; done while parked at LIMIT.
module drive_cmd_scheduler_sched_timer #(
  parameter int unsigned LIMIT   = 8,
  parameter int unsigned RST_VAL = 0,
  parameter int unsigned W       = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over counting; counting stops at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/drive_cmd_scheduler.sv
// Arbitrates estop / manual / autonomous drive commands, enforces dwell,
// inserts a braked Stop on left<->right reversal, and offers commands downstream.
module drive_cmd_scheduler
  import drive_cmd_scheduler_pkg::*;
#(
  parameter int unsigned MIN_HOLD       = 5_000_000,
  parameter int unsigned BRAKE_TIME     = 2_500_000,
  parameter int unsigned MANUAL_TIMEOUT = 50_000_000
) (
  input logic                 clk,
  input logic                 reset,
  drive_cmd_scheduler_if.slave bus
);

  localparam int unsigned HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int unsigned BRK_W  = $clog2(BRAKE_TIME + 1);
  localparam int unsigned MAN_W  = $clog2(MANUAL_TIMEOUT + 1);

  sched_state_t state_q;
  drive_cmd_t   cur_cmd_q;
  drive_cmd_t   pend_cmd_q;
  drive_cmd_t   man_cmd_q;
  logic         rev_q;
  logic         out_valid_q;

  drive_cmd_t   cand_c;
  src_t         src_c;
  logic         man_active_c;
  logic         take_c;
  logic         handshake_c;
  logic         brk_exit_c;

  logic              hold_done;
  logic              brk_done;
  logic              man_expired;
  logic              hold_load;
  logic [HOLD_W-1:0] hold_load_val;

  // Hold dwell: restarts on handshake, forced expired when a brake finishes.
  assign hold_load     = handshake_c || brk_exit_c;
  assign hold_load_val = brk_exit_c ? HOLD_W'(MIN_HOLD) : '0;

  drive_cmd_scheduler_sched_timer #(
    .LIMIT   (MIN_HOLD),
    .RST_VAL (MIN_HOLD),
    .W       (HOLD_W)
  ) u_hold_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (hold_load),
    .load_val_i (hold_load_val),
    .en_i       (state_q == ST_HOLD),
    .done_o     (hold_done)
  );

  // Brake dwell: counts 0..BRAKE_TIME-1, i.e. BRAKE_TIME cycles in BRAKE.
  drive_cmd_scheduler_sched_timer #(
    .LIMIT   (BRAKE_TIME - 1),
    .RST_VAL (0),
    .W       (BRK_W)
  ) u_brk_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (handshake_c && rev_q),
    .load_val_i ('0),
    .en_i       (state_q == ST_BRAKE),
    .done_o     (brk_done)
  );

  // Manual priority window as elapsed time since the last IR strobe;
  // parked at the limit (expired) out of reset.
  drive_cmd_scheduler_sched_timer #(
    .LIMIT   (MANUAL_TIMEOUT),
    .RST_VAL (MANUAL_TIMEOUT),
    .W       (MAN_W)
  ) u_man_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (bus.manual_valid),
    .load_val_i ('0),
    .en_i       (1'b1),
    .done_o     (man_expired)
  );

  assign man_active_c = !man_expired;

  // Source arbitration: estop, then live manual, then autonomous (Stop when invalid).
  always_comb begin
    src_c  = SRC_AUTO;
    cand_c = CMD_STOP;
    if (bus.estop) begin
      src_c  = SRC_ESTOP;
      cand_c = CMD_STOP;
    end else if (man_active_c) begin
      src_c  = SRC_MANUAL;
      cand_c = man_cmd_q;
    end else if (bus.auto_valid) begin
      cand_c = norm_cmd(bus.auto_cmd);
    end
  end

  // Transition qualifiers shared by the FSM and timers.
  assign take_c      = (state_q == ST_HOLD) && (cand_c != cur_cmd_q) &&
                       ((cand_c == CMD_STOP) || hold_done);
  assign handshake_c = (state_q == ST_ISSUE) && bus.out_ready;
  assign brk_exit_c  = (state_q == ST_BRAKE) && brk_done;

  // Manual command latch; updates even while estop overrides selection.
  always_ff @(posedge clk) begin
    if (reset) begin
      man_cmd_q <= CMD_STOP;
    end else if (bus.manual_valid) begin
      man_cmd_q <= norm_cmd(bus.manual_cmd);
    end
  end

  // Scheduler FSM with registered offer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      cur_cmd_q   <= CMD_STOP;
      pend_cmd_q  <= CMD_STOP;
      rev_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (take_c) begin
            rev_q       <= is_reversal(cur_cmd_q, cand_c);
            pend_cmd_q  <= is_reversal(cur_cmd_q, cand_c) ? CMD_STOP : cand_c;
            out_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.out_ready) begin
            cur_cmd_q   <= pend_cmd_q;
            out_valid_q <= 1'b0;
            state_q     <= rev_q ? ST_BRAKE : ST_HOLD;
          end
        end
        ST_BRAKE: begin
          if (brk_done) begin
            state_q <= ST_HOLD;
          end
        end
        default: begin
          state_q     <= ST_HOLD;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_cmd    = pend_cmd_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.active_src = src_c;
  assign bus.busy       = (state_q != ST_HOLD);

endmodule

// File: tb/tb_drive_cmd_scheduler.sv
// Directed + randomized bench for drive_cmd_scheduler against a cycle-level reference model.
module tb_drive_cmd_scheduler;

  localparam int unsigned MIN_HOLD       = 8;
  localparam int unsigned BRAKE_TIME     = 4;
  localparam int unsigned MANUAL_TIMEOUT = 20;

  logic clk = 1'b0;
  logic reset;

  drive_cmd_scheduler_if bus ();

  drive_cmd_scheduler #(
    .MIN_HOLD       (MIN_HOLD),
    .BRAKE_TIME     (BRAKE_TIME),
    .MANUAL_TIMEOUT (MANUAL_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: "what is committed / offered / how long is left".
  int m_cur, m_pend, m_dwell, m_brake_left, m_man_left, m_man_cmd, m_offer, m_rev;

  function automatic int norm(input int c);
    return (c > 5) ? 0 : c;
  endfunction

  // -1 left family, +1 right family, 0 neutral.
  function automatic int fam(input int c);
    if (c == 1 || c == 2) return -1;
    if (c == 4 || c == 5) return 1;
    return 0;
  endfunction

  function automatic int m_cand();
    if (bus.estop) return 0;
    if (m_man_left > 0) return m_man_cmd;
    if (bus.auto_valid) return norm(int'(bus.auto_cmd));
    return 0;
  endfunction

  function automatic int m_src();
    if (bus.estop) return 2;
    if (m_man_left > 0) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_pend = 0; m_dwell = MIN_HOLD; m_brake_left = 0;
    m_man_left = 0; m_man_cmd = 0; m_offer = 0; m_rev = 0;
  endtask

  // Advance the model across one rising edge using the inputs sampled there.
  task automatic model_step();
    int c;
    if (reset) begin
      model_reset();
      return;
    end
    c = m_cand();
    if (m_offer != 0) begin
      if (bus.out_ready) begin
        m_cur = m_pend; m_dwell = 0; m_offer = 0;
        if (m_rev != 0) m_brake_left = BRAKE_TIME;
      end
    end else if (m_brake_left > 0) begin
      m_brake_left--;
      if (m_brake_left == 0) m_dwell = MIN_HOLD;
    end else begin
      if (c != m_cur && (c == 0 || m_dwell >= MIN_HOLD)) begin
        m_rev   = (fam(c) * fam(m_cur) < 0) ? 1 : 0;
        m_pend  = (m_rev != 0) ? 0 : c;
        m_offer = 1;
      end
      if (m_dwell < MIN_HOLD) m_dwell++;
    end
    if (bus.manual_valid) begin
      m_man_cmd  = norm(int'(bus.manual_cmd));
      m_man_left = MANUAL_TIMEOUT;
    end else if (m_man_left > 0) begin
      m_man_left--;
    end
  endtask

  // Apply one cycle of inputs, compare mid-cycle, then step the model at the edge.
  task automatic cycle(input int rst, input int acmd, input int aval, input int mcmd,
                       input int mval, input int es, input int rdy);
    reset            = (rst != 0);
    bus.auto_cmd     = 3'(acmd);
    bus.auto_valid   = (aval != 0);
    bus.manual_cmd   = 3'(mcmd);
    bus.manual_valid = (mval != 0);
    bus.estop        = (es != 0);
    bus.out_ready    = (rdy != 0);
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(m_offer));
    if (m_offer != 0) chk("out_cmd", 32'(bus.out_cmd), 32'(m_pend));
    chk("busy", 32'(bus.busy), 32'((m_offer != 0) || (m_brake_left > 0)));
    chk("active_src", 32'(bus.active_src), 32'(m_src()));
    @(posedge clk);
    model_step();
    #1;
  endtask

  int a_cmd, a_val, m_cmd, es, rdy;

  initial begin
    reset = 1'b1;
    bus.auto_cmd = '0; bus.auto_valid = 1'b0; bus.manual_cmd = '0;
    bus.manual_valid = 1'b0; bus.estop = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_cmd", 32'(bus.out_cmd), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_active_src", 32'(bus.active_src), 32'd0);
    @(posedge clk); #1;

    // First command after reset, then dwell before a Left change.
    cycle(0, 3, 1, 0, 0, 0, 1);
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_cmd", 32'(bus.out_cmd), 32'd3);
    repeat (3) cycle(0, 3, 1, 0, 0, 0, 1);
    repeat (10) cycle(0, 2, 1, 0, 0, 0, 1);
    // Reversal Left -> Right with brake.
    repeat (22) cycle(0, 4, 1, 0, 0, 0, 1);
    // Stop issues without waiting for dwell.
    repeat (3) cycle(0, 3, 1, 0, 0, 0, 1);
    repeat (3) cycle(0, 0, 1, 0, 0, 0, 1);
    repeat (10) cycle(0, 3, 1, 0, 0, 0, 1);
    // Manual override then timeout.
    cycle(0, 3, 1, 5, 1, 0, 1);
    repeat (30) cycle(0, 3, 1, 0, 0, 0, 1);
    // Backpressure with estop rising during an offer.
    repeat (12) cycle(0, 1, 1, 0, 0, 0, 1);
    repeat (12) cycle(0, 3, 1, 0, 0, 0, 0);
    repeat (3) cycle(0, 3, 1, 0, 0, 1, 0);
    repeat (4) cycle(0, 3, 1, 0, 0, 1, 1);
    // Reset while offering.
    repeat (12) cycle(0, 5, 1, 0, 0, 0, 0);
    cycle(1, 5, 1, 0, 0, 0, 0);
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_cmd", 32'(bus.out_cmd), 32'd0);
    repeat (3) cycle(0, 5, 1, 0, 0, 0, 1);

    // Randomized traffic.
    a_cmd = 3; a_val = 1; es = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) a_cmd = int'($urandom_range(0, 7));
      a_val = ($urandom_range(0, 15) != 0) ? 1 : 0;
      if ($urandom_range(0, 39) == 0) es = 1 - es;
      m_cmd = int'($urandom_range(0, 7));
      rdy   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      cycle(($urandom_range(0, 699) == 0) ? 1 : 0, a_cmd, a_val, m_cmd,
            ($urandom_range(0, 59) == 0) ? 1 : 0, es, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
